// File: rtl/hazard_forward_unit.sv
// Hazard resolution for the five-stage pipeline: EX/store forwarding
// selects, load-use and mult/div stalls, and the stall-only RAW mode.
module hazard_forward_unit #(
  parameter int REGADDR_W = 5,
  parameter int LOAD_LAT  = 1,
  parameter int MD_LAT    = 8,
  parameter int FWD_EN    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REGADDR_W-1:0] ifidrs,
  input  logic [REGADDR_W-1:0] ifidrt,
  input  logic                 ifidmduse,
  input  logic [REGADDR_W-1:0] idexrs,
  input  logic [REGADDR_W-1:0] idexrt,
  input  logic [REGADDR_W-1:0] idexregmuxout,
  input  logic                 idexregwr,
  input  logic                 idexmemrd,
  input  logic                 idexmemwr,
  input  logic                 idexmdstart,
  input  logic                 exmemregwr,
  input  logic                 exmemmemwr,
  input  logic [REGADDR_W-1:0] exmemregmuxout,
  input  logic [REGADDR_W-1:0] exmemrt,
  input  logic                 memwbregwr,
  input  logic [REGADDR_W-1:0] memwbregmuxout,
  output logic [1:0]           aluforward1,
  output logic [1:0]           aluforward2,
  output logic                 memdata,
  output logic                 memdata2,
  output logic                 stall,
  output logic                 bubble,
  output logic                 mdbusy
);

  localparam int LU_W = $clog2(LOAD_LAT + 1);
  localparam int MD_W = $clog2(MD_LAT + 1);

  typedef enum logic {
    LU_IDLE,
    LU_HOLD
  } lu_state_t;

  lu_state_t       lu_state, lu_state_n;
  logic [LU_W-1:0] lu_cnt, lu_cnt_n;
  logic [MD_W-1:0] md_cnt;
  logic            lu_hit, lu_stall, so_haz;

  // register 0 is hardwired, so it never creates a dependency
  function automatic logic hit(
    input logic [REGADDR_W-1:0] a,
    input logic [REGADDR_W-1:0] b
  );
    return (a != '0) && (a == b);
  endfunction

  logic ex_rs, ex_rt, wb_rs, wb_rt;

  assign ex_rs = exmemregwr & hit(exmemregmuxout, idexrs);
  assign ex_rt = exmemregwr & hit(exmemregmuxout, idexrt);
  assign wb_rs = memwbregwr & hit(memwbregmuxout, idexrs);
  assign wb_rt = memwbregwr & hit(memwbregmuxout, idexrt);

  always_comb begin
    aluforward1 = 2'b00;
    aluforward2 = 2'b00;
    memdata     = 1'b0;
    memdata2    = 1'b0;
    if (FWD_EN != 0) begin
      if (ex_rs)      aluforward1 = 2'b10;
      else if (wb_rs) aluforward1 = 2'b01;
      // stores take rt through the memdata path instead
      if (!idexmemwr) begin
        if (ex_rt)      aluforward2 = 2'b10;
        else if (wb_rt) aluforward2 = 2'b01;
      end
      memdata  = exmemmemwr & memwbregwr
               & hit(exmemrt, memwbregmuxout);
      memdata2 = idexmemwr & wb_rt;
    end
  end

  assign lu_hit = idexmemrd & idexregwr
                & (hit(idexregmuxout, ifidrs)
                 | hit(idexregmuxout, ifidrt));

  always_comb begin
    so_haz = 1'b0;
    if (FWD_EN == 0) begin
      so_haz = (idexregwr
               & (hit(idexregmuxout, ifidrs)
                | hit(idexregmuxout, ifidrt)))
             | (exmemregwr
               & (hit(exmemregmuxout, ifidrs)
                | hit(exmemregmuxout, ifidrt)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_state <= LU_IDLE;
      lu_cnt   <= '0;
    end else begin
      lu_state <= lu_state_n;
      lu_cnt   <= lu_cnt_n;
    end
  end

  always_comb begin
    lu_state_n = lu_state;
    lu_cnt_n   = lu_cnt;
    lu_stall   = 1'b0;
    case (lu_state)
      LU_IDLE: begin
        if (lu_hit) begin
          lu_stall = 1'b1;
          if (LOAD_LAT > 1) begin
            lu_cnt_n   = LU_W'(LOAD_LAT - 1);
            lu_state_n = LU_HOLD;
          end
        end
      end
      LU_HOLD: begin
        lu_stall = 1'b1;
        lu_cnt_n = lu_cnt - LU_W'(1);
        if (lu_cnt == LU_W'(1)) lu_state_n = LU_IDLE;
      end
      default: lu_state_n = LU_IDLE;
    endcase
  end

  // a new issue restarts the busy window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt <= '0;
    end else if (idexmdstart) begin
      md_cnt <= MD_W'(MD_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

  assign mdbusy = (md_cnt != '0);
  assign stall  = lu_stall | (mdbusy & ifidmduse) | so_haz;
  assign bubble = stall;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: vector table, corner sequences and a
// randomized run against a cycle-count reference model.
module tb_hazard_forward_unit;

  localparam int LA = 2, MA = 8;
  localparam int LB = 1, MB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] ifidrs, ifidrt, idexrs, idexrt, idexregmuxout;
  logic [4:0] exmemregmuxout, exmemrt, memwbregmuxout;
  logic ifidmduse, idexregwr, idexmemrd, idexmemwr, idexmdstart;
  logic exmemregwr, exmemmemwr, memwbregwr;

  logic [1:0] af1a, af2a, af1b, af2b;
  logic mda, md2a, sta, bua, mba;
  logic mdb, md2b, stb, bub, mbb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(
    .REGADDR_W(5), .LOAD_LAT(LA), .MD_LAT(MA), .FWD_EN(1)
  ) ua (
    .clk(clk), .rst(rst),
    .ifidrs(ifidrs), .ifidrt(ifidrt), .ifidmduse(ifidmduse),
    .idexrs(idexrs), .idexrt(idexrt), .idexregmuxout(idexregmuxout),
    .idexregwr(idexregwr), .idexmemrd(idexmemrd),
    .idexmemwr(idexmemwr), .idexmdstart(idexmdstart),
    .exmemregwr(exmemregwr), .exmemmemwr(exmemmemwr),
    .exmemregmuxout(exmemregmuxout), .exmemrt(exmemrt),
    .memwbregwr(memwbregwr), .memwbregmuxout(memwbregmuxout),
    .aluforward1(af1a), .aluforward2(af2a),
    .memdata(mda), .memdata2(md2a),
    .stall(sta), .bubble(bua), .mdbusy(mba)
  );

  hazard_forward_unit #(
    .REGADDR_W(5), .LOAD_LAT(LB), .MD_LAT(MB), .FWD_EN(0)
  ) ub (
    .clk(clk), .rst(rst),
    .ifidrs(ifidrs), .ifidrt(ifidrt), .ifidmduse(ifidmduse),
    .idexrs(idexrs), .idexrt(idexrt), .idexregmuxout(idexregmuxout),
    .idexregwr(idexregwr), .idexmemrd(idexmemrd),
    .idexmemwr(idexmemwr), .idexmdstart(idexmdstart),
    .exmemregwr(exmemregwr), .exmemmemwr(exmemmemwr),
    .exmemregmuxout(exmemregmuxout), .exmemrt(exmemrt),
    .memwbregwr(memwbregwr), .memwbregmuxout(memwbregmuxout),
    .aluforward1(af1b), .aluforward2(af2b),
    .memdata(mdb), .memdata2(md2b),
    .stall(stb), .bubble(bub), .mdbusy(mbb)
  );

  typedef struct {
    logic [4:0] rs, rt, dst;
    logic rw, mr, mw;
    logic xw;
    logic [4:0] xd;
    logic xmw;
    logic [4:0] xrt;
    logic ww;
    logic [4:0] wd;
    logic [4:0] frs, frt;
    logic [1:0] e1, e2;
    logic emd, emd2, est;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    ifidrs = 0; ifidrt = 0; ifidmduse = 0;
    idexrs = 0; idexrt = 0; idexregmuxout = 0;
    idexregwr = 0; idexmemrd = 0; idexmemwr = 0; idexmdstart = 0;
    exmemregwr = 0; exmemmemwr = 0; exmemregmuxout = 0; exmemrt = 0;
    memwbregwr = 0; memwbregmuxout = 0;
  endtask

  task automatic apply(input vec_t v);
    clr();
    idexrs = v.rs; idexrt = v.rt; idexregmuxout = v.dst;
    idexregwr = v.rw; idexmemrd = v.mr; idexmemwr = v.mw;
    exmemregwr = v.xw; exmemregmuxout = v.xd;
    exmemmemwr = v.xmw; exmemrt = v.xrt;
    memwbregwr = v.ww; memwbregmuxout = v.wd;
    ifidrs = v.frs; ifidrt = v.frt;
  endtask

  // reference model: stall cycles still owed and mult/div cycles left
  int lua, mda_m, lub, mdb_m;

  function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
    return a != 0 && a == b;
  endfunction

  function automatic bit m_luhit();
    return idexmemrd && idexregwr &&
      (dep(idexregmuxout, ifidrs) || dep(idexregmuxout, ifidrt));
  endfunction

  function automatic logic [1:0] m_sel(input logic [4:0] src);
    if (exmemregwr && dep(exmemregmuxout, src)) return 2'b10;
    if (memwbregwr && dep(memwbregmuxout, src)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall(input int lu, input int md, input bit fwd);
    bit raw;
    raw = (idexregwr && (dep(idexregmuxout, ifidrs) ||
                         dep(idexregmuxout, ifidrt))) ||
          (exmemregwr && (dep(exmemregmuxout, ifidrs) ||
                          dep(exmemregmuxout, ifidrt)));
    return (m_luhit() && lu == 0) || lu > 0 ||
           (md > 0 && ifidmduse) || (!fwd && raw);
  endfunction

  task automatic m_step();
    bit h;
    h = m_luhit();
    if (lua > 0) lua--; else if (h) lua = LA - 1;
    if (lub > 0) lub--; else if (h) lub = LB - 1;
    if (idexmdstart) mda_m = MA; else if (mda_m > 0) mda_m--;
    if (idexmdstart) mdb_m = MB; else if (mdb_m > 0) mdb_m--;
  endtask

  initial begin
    tbl[0] = '{3,0,0,0,0,0, 1,3,0,0, 1,3, 0,0, 2'b10,2'b00,0,0,0};
    tbl[1] = '{3,0,0,0,0,0, 0,3,0,0, 1,3, 0,0, 2'b01,2'b00,0,0,0};
    tbl[2] = '{0,0,0,1,0,0, 1,0,0,0, 1,0, 0,0, 2'b00,2'b00,0,0,0};
    tbl[3] = '{0,5,0,0,0,1, 1,5,0,0, 0,0, 0,0, 2'b00,2'b00,0,0,0};
    tbl[4] = '{0,5,0,0,0,1, 1,5,0,0, 1,5, 0,0, 2'b00,2'b00,0,1,0};
    tbl[5] = '{0,6,0,0,0,0, 1,6,0,0, 0,0, 0,0, 2'b00,2'b10,0,0,0};
    tbl[6] = '{0,0,0,0,0,0, 0,0,1,9, 1,9, 0,0, 2'b00,2'b00,1,0,0};
    tbl[7] = '{0,0,0,0,0,0, 0,0,1,0, 1,0, 0,0, 2'b00,2'b00,0,0,0};
    tbl[8] = '{0,0,0,1,1,0, 0,0,0,0, 0,0, 0,0, 2'b00,2'b00,0,0,0};
    tbl[9] = '{0,2,0,0,0,0, 0,0,0,0, 1,2, 0,0, 2'b00,2'b01,0,0,0};

    clr();
    #1;
    chk("rst_stall", sta, 0);
    chk("rst_mdbusy", mba, 0);
    chk("rst_af1", af1a, 0);
    chk("rst_b_stall", stb, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk($sformatf("tbl%0d_af1", i), af1a, tbl[i].e1);
      chk($sformatf("tbl%0d_af2", i), af2a, tbl[i].e2);
      chk($sformatf("tbl%0d_memdata", i), mda, tbl[i].emd);
      chk($sformatf("tbl%0d_memdata2", i), md2a, tbl[i].emd2);
      chk($sformatf("tbl%0d_stall", i), sta, tbl[i].est);
    end

    // load-use with LOAD_LAT=2
    @(negedge clk);
    clr();
    idexmemrd = 1; idexregwr = 1; idexregmuxout = 7; ifidrt = 7;
    #1;
    chk("lu_c0_stall", sta, 1);
    chk("lu_c0_bubble", bua, 1);
    @(negedge clk);
    clr();
    #1;
    chk("lu_c1_stall", sta, 1);
    chk("lu_c1_bubble", bua, 1);
    @(negedge clk);
    #1;
    chk("lu_c2_stall", sta, 0);
    chk("lu_c2_bubble", bua, 0);

    // mult/div busy window
    @(negedge clk);
    clr();
    idexmdstart = 1;
    #1;
    chk("md_c0_busy", mba, 0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      idexmdstart = 0;
      ifidmduse = (c == 4 || c == 9);
      #1;
      chk($sformatf("md_c%0d_busy", c), mba, (c <= 8));
      if (c == 4) chk("md_c4_stall", sta, 1);
      if (c == 9) chk("md_c9_stall", sta, 0);
    end

    // stall-only build
    @(negedge clk);
    clr();
    exmemregwr = 1; exmemregmuxout = 4; ifidrs = 4; idexrs = 4;
    #1;
    chk("so_stall", stb, 1);
    chk("so_af1", af1b, 0);
    chk("fwd_af1", af1a, 2'b10);
    chk("fwd_stall", sta, 0);

    // asynchronous reset mid-stall and mid-busy
    @(negedge clk);
    clr();
    idexmdstart = 1;
    idexmemrd = 1; idexregwr = 1; idexregmuxout = 7; ifidrt = 7;
    @(negedge clk);
    clr();
    ifidmduse = 1;
    #1;
    chk("ar_pre_stall", sta, 1);
    chk("ar_pre_busy", mba, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_stall", sta, 0);
    chk("ar_busy", mba, 0);
    chk("ar_b_busy", mbb, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_rel_stall", sta, 0);
    chk("ar_rel_busy", mba, 0);
    @(negedge clk);
    #1;
    chk("ar_post_stall", sta, 0);
    chk("ar_post_busy", mba, 0);
    chk("ar_post_b_busy", mbb, 0);

    // randomized run
    lua = 0; mda_m = 0; lub = 0; mdb_m = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ifidrs = 5'($urandom_range(0, 3));
      ifidrt = 5'($urandom_range(0, 3));
      idexrs = 5'($urandom_range(0, 3));
      idexrt = 5'($urandom_range(0, 3));
      idexregmuxout = 5'($urandom_range(0, 3));
      exmemregmuxout = 5'($urandom_range(0, 3));
      exmemrt = 5'($urandom_range(0, 3));
      memwbregmuxout = 5'($urandom_range(0, 3));
      ifidmduse = 1'($urandom_range(0, 1));
      idexregwr = 1'($urandom_range(0, 1));
      idexmemrd = 1'($urandom_range(0, 1));
      idexmemwr = 1'($urandom_range(0, 1));
      idexmdstart = ($urandom_range(0, 7) == 0);
      exmemregwr = 1'($urandom_range(0, 1));
      exmemmemwr = 1'($urandom_range(0, 1));
      memwbregwr = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_af1", af1a, m_sel(idexrs));
      chk("rnd_af2", af2a, idexmemwr ? 2'b00 : m_sel(idexrt));
      chk("rnd_memdata", mda,
          exmemmemwr && memwbregwr && dep(exmemrt, memwbregmuxout));
      chk("rnd_memdata2", md2a,
          idexmemwr && memwbregwr && dep(idexrt, memwbregmuxout));
      chk("rnd_stall", sta, m_stall(lua, mda_m, 1));
      chk("rnd_bubble", bua, m_stall(lua, mda_m, 1));
      chk("rnd_mdbusy", mba, mda_m > 0);
      chk("rnd_b_fwd", {af1b, af2b, mdb, md2b}, 0);
      chk("rnd_b_stall", stb, m_stall(lub, mdb_m, 0));
      chk("rnd_b_bubble", bub, m_stall(lub, mdb_m, 0));
      chk("rnd_b_mdbusy", mbb, mdb_m > 0);
      @(posedge clk);
      m_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
